// File: rtl/fadd_accum_ctrl.sv
// fadd_accum_ctrl
//   Reduces a stream of IEEE-754 single-precision operands to one sum by
//   driving an external combinational float adder with the running
//   accumulator and each new operand, then capturing the result.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_data operand, in_last marks
//                         the final element of the reduction
//   add_a/add_b           to adder (accumulator, new operand)
//   add_res/add_ovf       from adder (result, overflow flag)
//   out_valid/out_ready   result handshake; out_sum, out_count (saturating
//                         element count), out_ovf (sticky adder overflow)
//
// state  | meaning
// ACCEPT | waiting for an operand; in_ready high
// EXEC   | adder settling on add_a/add_b; result captured at cycle end
// DONE   | final sum presented; waiting for out_ready
module fadd_accum_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_res,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCEPT, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      out_sum_q, out_sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic             last_q, last_d;

  logic [31:0]      acc_new;
  logic             ovf_new;
  logic [CNT_W-1:0] count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      add_a_q     <= '0;
      add_b_q     <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      count_q     <= '0;
      out_count_q <= '0;
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      count_q     <= count_d;
      out_count_q <= out_count_d;
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    // The first element of a reduction bypasses the adder so the sum is
    // bit-exact to the operand (no 0 + x rounding or -0 sign issues).
    acc_new   = (count_q == '0) ? add_b_q : add_res;
    ovf_new   = (count_q == '0) ? ovf_q : (ovf_q | add_ovf);
    count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    count_d     = count_q;
    out_count_d = out_count_q;
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
    last_d      = last_q;

    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          add_a_d = acc_q;
          add_b_d = in_data;
          last_d  = in_last;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d   = acc_new;
        ovf_d   = ovf_new;
        count_d = count_inc;
        if (last_q) begin
          out_sum_d   = acc_new;
          out_count_d = count_inc;
          out_ovf_d   = ovf_new;
          state_d     = DONE;
        end else begin
          state_d = ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == DONE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fadd_accum_ctrl.sv
// Bench for fadd_accum_ctrl: two instances (CNT_W = 16 and CNT_W = 2) share
// stimulus; each has its own copy of a synthetic adder. The reference model
// folds each reduction with the same adder function at transaction level.
module tb_fadd_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        dead_mode = 1'b0;
  logic        ovf_force = 1'b0;
  logic        ovf_rand = 1'b0;

  logic        in_ready_w, out_valid_w, out_ovf_w, add_ovf_w;
  logic [31:0] add_a_w, add_b_w, add_res_w, out_sum_w;
  logic [15:0] out_count_w;

  logic        in_ready_n, out_valid_n, out_ovf_n, add_ovf_n;
  logic [31:0] add_a_n, add_b_n, add_res_n, out_sum_n;
  logic [1:0]  out_count_n;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [31:0] m_acc;
  logic        m_ovf;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] adder(input logic [31:0] a, input logic [31:0] b,
                                        input logic dead);
    if (dead) return 32'hDEADBEEF;
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b + 32'd1;
  endfunction

  function automatic logic ovf_fn(input logic [31:0] a, input logic [31:0] b,
                                  input logic f, input logic r);
    return f | (r & (^(a[7:0] & b[7:0])));
  endfunction

  assign add_res_w = adder(add_a_w, add_b_w, dead_mode);
  assign add_ovf_w = ovf_fn(add_a_w, add_b_w, ovf_force, ovf_rand);
  assign add_res_n = adder(add_a_n, add_b_n, dead_mode);
  assign add_ovf_n = ovf_fn(add_a_n, add_b_n, ovf_force, ovf_rand);

  fadd_accum_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
    .add_a(add_a_w), .add_b(add_b_w), .add_res(add_res_w), .add_ovf(add_ovf_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
    .out_count(out_count_w), .out_ovf(out_ovf_w)
  );

  fadd_accum_ctrl #(.CNT_W(2)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_last(in_last),
    .add_a(add_a_n), .add_b(add_b_n), .add_res(add_res_n), .add_ovf(add_ovf_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_sum(out_sum_n),
    .out_count(out_count_n), .out_ovf(out_ovf_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Send one operand; checks adder inputs during EXEC and the outcome after it.
  task automatic send(input logic [31:0] d, input logic l, input logic f);
    int n = 0;
    while (!in_ready_w && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {31'd0, in_ready_w}, 32'd1);
    ovf_force = f;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom; in_last = $urandom_range(0, 1);
    check("exec_in_ready", {31'd0, in_ready_w}, 32'd0);
    check("exec_add_a", add_a_w, m_acc);
    check("exec_add_b", add_b_w, d);
    check("exec_add_a_n", add_a_n, m_acc);
    if (m_cnt == 0) m_acc = d;
    else begin
      m_ovf = m_ovf | ovf_fn(m_acc, d, f, ovf_rand);
      m_acc = adder(m_acc, d, dead_mode);
    end
    m_cnt++;
    @(posedge clk); #1;
    ovf_force = 1'b0;
    if (l) begin
      check("done_valid", {31'd0, out_valid_w}, 32'd1);
      check("done_sum", out_sum_w, m_acc);
      check("done_count16", {16'd0, out_count_w}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("done_count2", {30'd0, out_count_n}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      check("done_sum_n", out_sum_n, m_acc);
      check("done_ovf", {31'd0, out_ovf_w}, {31'd0, m_ovf});
      check("done_in_ready", {31'd0, in_ready_w}, 32'd0);
    end else begin
      check("mid_valid", {31'd0, out_valid_w}, 32'd0);
      check("mid_in_ready", {31'd0, in_ready_w}, 32'd1);
    end
  endtask

  // Hold backpressure for 'hold' cycles, then take the result.
  task automatic take(input int hold);
    logic [31:0] s;
    logic [15:0] c;
    s = out_sum_w;
    c = out_count_w;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid_w}, 32'd1);
      check("bp_sum", out_sum_w, s);
      check("bp_count", {16'd0, out_count_w}, {16'd0, c});
      check("bp_in_ready", {31'd0, in_ready_w}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("take_valid", {31'd0, out_valid_w}, 32'd0);
    check("take_in_ready", {31'd0, in_ready_w}, 32'd1);
    model_clear();
  endtask

  initial begin
    model_clear();
    #12;
    check("rst_in_ready", {31'd0, in_ready_w}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_w}, 32'd0);
    check("rst_add_a", add_a_w, 32'd0);
    check("rst_add_b", add_b_w, 32'd0);
    check("rst_out_sum", out_sum_w, 32'd0);
    check("rst_out_count", {16'd0, out_count_w}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf_w}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle does nothing
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready_valid", {31'd0, out_valid_w}, 32'd0);
    check("idle_ready_in_ready", {31'd0, in_ready_w}, 32'd1);

    // 1.0 + 2.0
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b0);
    check("two_sum_const", out_sum_w, 32'h40400000);
    take(5);

    // one-element reduction with adder poisoned
    dead_mode = 1'b1;
    send(32'hC0A00000, 1'b1, 1'b0);
    check("one_sum_const", out_sum_w, 32'hC0A00000);
    take(0);
    dead_mode = 1'b0;

    // sticky overflow on the 2nd add only
    send(32'h3F800000, 1'b0, 1'b1);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b1);
    take(1);
    send(32'h11111111, 1'b0, 1'b0);
    send(32'h22222222, 1'b0, 1'b0);
    send(32'h33333333, 1'b0, 1'b1);
    send(32'h44444444, 1'b1, 1'b0);
    check("sticky_const", {31'd0, out_ovf_w}, 32'd1);
    take(0);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    check("no_ovf_const", {31'd0, out_ovf_w}, 32'd0);
    take(0);

    // saturation on the narrow instance
    for (int i = 0; i < 5; i++) send(32'h3F800000, (i == 4), 1'b0);
    check("sat_count2", {30'd0, out_count_n}, 32'd3);
    check("sat_count16", {16'd0, out_count_w}, 32'd5);
    take(2);

    // reset during EXEC of the 2nd of 3 elements
    send(32'h3F800000, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_exec", {31'd0, in_ready_w}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid_w}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready_w}, 32'd1);
    check("arst_add_a", add_a_w, 32'd0);
    check("arst_add_b", add_b_w, 32'd0);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h40000000, 1'b1, 1'b0);
    check("post_rst_sum", out_sum_w, 32'h40000000);
    check("post_rst_count", {16'd0, out_count_w}, 32'd1);
    take(0);

    // randomized reductions
    ovf_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send($urandom, (k == len - 1), ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 1) == 1 && k != len - 1) begin
          @(posedge clk); #1;
        end
      end
      take($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
